fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Packet-aware round-robin arbiter sharing the single write port of the async FIFO among `NUM_REQ` requesters in the write clock domain. It sits directly in front of the write-pointer logic: it drives `w_en` and the write data, and honours the registered `full` flag. A grant is held for a whole packet, delimited by `last`. An oversize guard prevents one requester from monopolising the FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: FIFO data width.
- `MAX_PKT_BEATS`, 16: maximum beats per grant, ≥1.
- `wclk`  in  1  write clock; single clock domain.
- `wrst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  final beat of packet.
- `req_ready`  out  NUM_REQ  beat accepted when `req_valid[i] & req_ready[i]`.
- `full`  in  1  FIFO full, registered, from the write-pointer logic.
- `w_en`  out  1  FIFO write enable.
- `w_data`  out  DATA_WIDTH  FIFO write data.
- `gnt_id`  out  $clog2(NUM_REQ)  current grant owner.
- `busy`  out  1  a grant is held.
- `pkt_oversize`  out  1  one-cycle pulse on forced release.
- `pkt_count`  out  16  completed grants, wraps modulo 2^16.

## Operation
- FSM with two states.
  - ARB_IDLE: if any `req_valid`, select the first valid requester searching upward from `rr_ptr`, wrapping. Register `gnt_id`, go to ARB_BUSY, clear `beat_cnt`. If no requester is valid, stay in ARB_IDLE.
  - ARB_BUSY, per beat. A beat is `req_valid[gnt_id] & !full`.
    - `w_en = 1` and `w_data = req_data[gnt_id]`.
    - `req_ready[gnt_id] = !full`; all other `req_ready` bits are 0.
- Grant ends on a beat with `req_last[gnt_id]`, or on the beat where `beat_cnt == MAX_PKT_BEATS-1`.
  - If the beat without `last` hit the limit, pulse `pkt_oversize`.
  - On either end: `rr_ptr <= (gnt_id+1) mod NUM_REQ`, `pkt_count++`, return to ARB_IDLE.
- A forced release does not drop data. The requester's remaining beats compete as a new grant.
- `req_valid[gnt_id]` low while in ARB_BUSY: hold the grant and stall. This is a bubble, not a release.
- `full` high: `w_en = 0` and `req_ready = 0`, and `beat_cnt` holds. `w_en` is never asserted while `full = 1`.
- In ARB_IDLE: `w_en = 0`, `req_ready = 0`, and `w_data` is don't-care but driven as `req_data[gnt_id]`.
- `beat_cnt` width: $clog2(MAX_PKT_BEATS+1). It increments only on accepted beats.

## Timing
- Reset (`wrst` sampled high at a `wclk` edge) sets:
  - state ARB_IDLE, `rr_ptr` 0, `gnt_id` 0, `beat_cnt` 0;
  - `busy` 0, `pkt_oversize` 0, `pkt_count` 0, `w_en` 0, `req_ready` all 0.
- Reset mid-packet aborts the grant immediately. Beats already written stay in the FIFO.
- Latency: a valid request in ARB_IDLE at edge N gives `busy = 1` after edge N, with the first accepted beat in that cycle. There is a 1-cycle arbitration bubble per grant.
- End of grant: the last beat is accepted in cycle N. `busy` is 0 in cycle N+1, even if other requests are pending. The next grant is in cycle N+2.
- Throughput: one beat per cycle inside a grant when valid and not full.
- `w_en`, `w_data`, `req_ready` are combinational from registered state, `req_valid`, and `full`. There is no combinational path from `req_data` to `req_ready`.
- `busy`, `gnt_id`, `pkt_count`, `pkt_oversize` are registered.
- Simultaneous `last` and forced limit on the same beat: normal completion, no `pkt_oversize`.
- `full` rising in the same cycle as a pending last beat: the beat is not accepted and the grant persists.

## Structure
- Package `fifo_arb_pkg`: `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;` and the `pkt_count` width constant `PKT_CNT_W = 16`.
- Sub-module `rr_pick`: combinational rotating-priority search. Inputs are the `req` vector and `ptr`; outputs are `any` and `idx`. Instantiated once.

## Test plan
- Single requester: req 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last) → `gnt_id = 2`, `w_en` high 3 cycles, FIFO gets A1..A3, `pkt_count = 1`, `busy` low after.
- All 4 requesters continuously valid with 1-beat packets → grant order 0,1,2,3,0; one idle cycle between grants.
- Requester 1 sends a 20-beat packet, `MAX_PKT_BEATS = 16`, while requester 3 waits → 16 beats written, then `pkt_oversize` pulse, then requester 3's packet, then requester 1's remaining 4 beats.
- `full` asserted for 5 cycles mid-packet → `w_en = 0` and `req_ready = 0` throughout, `beat_cnt` holds, no data lost or duplicated.
- `wrst` asserted during beat 2 of a 4-beat packet → next cycle all outputs at reset values; `rr_ptr = 0`, so requester 0 wins the next contention.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned PKT_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of req at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Walk candidates from ptr upward; the first valid one wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (req[cand] && !any) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter for the async FIFO write port.
// A grant lasts until the owner's last beat or the beat limit, whichever first.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAX_PKT_BEATS = 16
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  output logic                          pkt_oversize,
  output logic [PKT_CNT_W-1:0]          pkt_count
);

  localparam int unsigned    IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned    BCNT_W   = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [BCNT_W-1:0] BEAT_LIM = BCNT_W'(MAX_PKT_BEATS - 1);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                      busy_q, busy_d;
  logic                      ovs_q, ovs_d;
  logic [PKT_CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;

  logic                      pick_any;
  logic [IDX_W-1:0]          pick_idx;
  logic                      beat;
  logic [DATA_WIDTH-1:0]     lane_data [NUM_REQ];

  // Split the flat data bus into per-requester lanes.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Write-port handshake; depends only on state, req_valid and full.
  always_comb begin
    req_ready = '0;
    beat      = (state_q == ARB_BUSY) && req_valid[gnt_q] && !full;
    w_en      = beat;
    w_data    = lane_data[gnt_q];
    if ((state_q == ARB_BUSY) && !full) begin
      req_ready[gnt_q] = 1'b1;
    end
  end

  // Next-state: grant selection, beat counting and grant release.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    ovs_d      = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_BUSY;
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (req_last[gnt_q] || (beat_cnt_q == BEAT_LIM)) begin
            // A limit hit that coincides with last is a normal completion.
            state_d   = ARB_IDLE;
            rr_ptr_d  = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
            ovs_d     = !req_last[gnt_q];
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d == ARB_BUSY);
  end

  // State and registered outputs.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      ovs_q      <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
      ovs_q      <= ovs_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign gnt_id       = gnt_q;
  assign busy         = busy_q;
  assign pkt_oversize = ovs_q;
  assign pkt_count    = pkt_cnt_q;

endmodule : fifo_wr_arbiter
